// File: rtl/pipeline_pkg.sv
// Shared types and limits for the cascaded skid-buffer pipeline.
package pipeline_pkg;

  localparam int MAX_PIPE_DEPTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/skid_stage.sv
// One skid-buffer stage: a main entry that drives the output and a skid entry
// that catches the beat accepted in the cycle the downstream side stalls.
module skid_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  import pipeline_pkg::*;

  stage_state_e          state_r;
  stage_state_e          state_nxt_s;
  logic                  valid_r;
  logic                  ready_r;
  logic [DATA_WIDTH-1:0] main_r;
  logic [DATA_WIDTH-1:0] skid_r;
  logic                  accept_s;
  logic                  emit_s;
  logic                  load_main_s;
  logic                  main_from_skid_s;
  logic                  load_skid_s;

  // ready comes from a flop, so downstream stalls never ripple upstream combinationally
  assign in_ready  = ready_r & ~flush;
  assign out_valid = valid_r;
  assign out_data  = main_r;
  assign accept_s  = in_valid & in_ready;
  assign emit_s    = valid_r & out_ready;

  // next state and payload steering
  always_comb begin
    state_nxt_s      = state_r;
    load_main_s      = 1'b0;
    main_from_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_nxt_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_nxt_s = BUSY;
            load_main_s = 1'b1;
          end else begin
            state_nxt_s = EMPTY;
          end
        end
        BUSY: begin
          if (accept_s && emit_s) begin
            state_nxt_s = BUSY;
            load_main_s = 1'b1;
          end else if (accept_s) begin
            state_nxt_s = FULL;
            load_skid_s = 1'b1;
          end else if (emit_s) begin
            state_nxt_s = EMPTY;
          end else begin
            state_nxt_s = BUSY;
          end
        end
        FULL: begin
          if (emit_s) begin
            state_nxt_s      = BUSY;
            main_from_skid_s = 1'b1;
          end else begin
            state_nxt_s = FULL;
          end
        end
        default: state_nxt_s = EMPTY;
      endcase
    end
  end

  // control state with registered valid/ready decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      valid_r <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s != EMPTY);
      ready_r <= (state_nxt_s != FULL);
    end
  end

  // payload entries carry no reset; valid_r qualifies them
  always_ff @(posedge clk) begin
    if (load_main_s) begin
      main_r <= in_data;
    end else if (main_from_skid_s) begin
      main_r <= skid_r;
    end
    if (load_skid_s) begin
      skid_r <= in_data;
    end
  end

endmodule

// File: rtl/pipeline_chain.sv
// DEPTH cascaded skid stages with a beat-occupancy counter at the chain boundary.
module pipeline_chain #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 2,
  localparam int OCC_W      = $clog2(2*DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OCC_W-1:0]      occupancy
);
  import pipeline_pkg::*;

  if ((DEPTH < 1) || (DEPTH > MAX_PIPE_DEPTH)) begin : g_depth_check
    $error("pipeline_chain: DEPTH out of range");
  end

  logic [DEPTH:0]                 valid_s;
  logic [DEPTH:0]                 ready_s;
  logic [DEPTH:0][DATA_WIDTH-1:0] data_s;
  logic [OCC_W-1:0]               occ_r;
  logic                           in_fire_s;
  logic                           out_fire_s;

  assign valid_s[0]     = in_valid;
  assign data_s[0]      = in_data;
  assign in_ready       = ready_s[0];
  assign out_valid      = valid_s[DEPTH];
  assign out_data       = data_s[DEPTH];
  assign ready_s[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    skid_stage #(.DATA_WIDTH(DATA_WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_data  (data_s[i]),
      .in_valid (valid_s[i]),
      .in_ready (ready_s[i]),
      .out_data (data_s[i+1]),
      .out_valid(valid_s[i+1]),
      .out_ready(ready_s[i+1])
    );
  end

  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;
  assign occupancy  = occ_r;

  // beats held anywhere in the chain; a flush discards both fires of its cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (flush) begin
      occ_r <= {OCC_W{1'b0}};
    end else begin
      occ_r <= occ_r + OCC_W'(in_fire_s) - OCC_W'(out_fire_s);
    end
  end

endmodule

// File: tb/tb_pipeline_chain.sv
// Directed scoreboard bench for pipeline_chain with DATA_WIDTH=32, DEPTH=2.
module tb_pipeline_chain;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int OCC_W = $clog2(2*DEPTH+1);

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  int          checks;
  int          failures;
  int          cyc;
  int          occ_m;
  int          last_lat;
  bit          last_in_fire;
  int          out_cnt;
  int          first_out_edge;
  int          last_out_edge;
  logic [31:0] sb_data[$];
  int          sb_edge[$];

  pipeline_chain #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)))
    else begin
      failures++;
      $error("FAIL stall_stable observed out_valid=%0b out_data=%h", out_valid, out_data);
    end

  a_reset_invalid: assert property (@(posedge clk) !rst_n |-> !out_valid)
    else begin
      failures++;
      $error("FAIL reset_out_valid observed=%0b expected=0", out_valid);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    logic        inf;
    logic        outf;
    logic [31:0] exp_d;
    int          exp_e;
    #1;
    inf          = in_valid && in_ready;
    outf         = out_valid && out_ready;
    last_in_fire = inf;
    if (flush) begin
      sb_data.delete();
      sb_edge.delete();
      occ_m = 0;
    end else begin
      if (outf) begin
        chk("beat_expected", 32'(sb_data.size() > 0), 32'd1);
        if (sb_data.size() > 0) begin
          exp_d    = sb_data.pop_front();
          exp_e    = sb_edge.pop_front();
          chk("out_data", out_data, exp_d);
          last_lat = cyc + 1 - exp_e;
          chk("min_latency", 32'(last_lat >= DEPTH), 32'd1);
        end
        if (out_cnt == 0) first_out_edge = cyc + 1;
        last_out_edge = cyc + 1;
        out_cnt++;
      end
      if (inf) begin
        sb_data.push_back(in_data);
        sb_edge.push_back(cyc + 1);
      end
      occ_m = occ_m + int'(inf) - int'(outf);
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("occupancy", 32'(occupancy), 32'(occ_m));
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d, input int budget);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (last_in_fire) break;
    end
    chk("send_accepted", 32'(last_in_fire), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb_data.size() > 0; i++) tick();
    chk("drain_empty", 32'(sb_data.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; cyc = 0; occ_m = 0; last_lat = 0; out_cnt = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // reset state and release
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    rst_n = 1'b1;
    #1 chk("release_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 chk("release_in_ready_high", 32'(in_ready), 32'd1);
    @(negedge clk);

    // single beat, latency 2
    out_ready = 1'b1;
    send(32'hAAAA0001, 4);
    chk("single_occ1", 32'(occupancy), 32'd1);
    drain(6);
    chk("single_latency", 32'(last_lat), 32'd2);
    chk("single_occ0", 32'(occupancy), 32'd0);

    // fill to capacity with the output stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'(i), 4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_occ", 32'(occupancy), 32'd4);
    in_valid = 1'b1;
    in_data  = 32'h5;
    tick();
    tick();
    chk("fill_fifth_blocked", 32'(last_in_fire), 32'd0);
    out_ready = 1'b1;
    out_cnt   = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (last_in_fire) in_valid = 1'b0;
    end
    chk("fill_out_count", 32'(out_cnt), 32'd5);
    chk("fill_drained", 32'(sb_data.size()), 32'd0);

    // streaming at full rate
    out_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      send($urandom, 1);
    end
    drain(10);
    chk("stream_out_count", 32'(out_cnt), 32'd8);
    chk("stream_consecutive", 32'(last_out_edge - first_out_edge), 32'd7);
    chk("stream_latency", 32'(last_lat), 32'd2);

    // flush with three beats held
    out_ready = 1'b0;
    send(32'hF0000001, 4);
    send(32'hF0000002, 4);
    send(32'hF0000003, 4);
    chk("flush_pre_occ", 32'(occupancy), 32'd3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEAD0000;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    out_ready = 1'b1;
    out_cnt   = 0;
    repeat (4) tick();
    chk("flush_no_beats", 32'(out_cnt), 32'd0);

    // asynchronous reset with two beats held
    out_ready = 1'b0;
    send(32'hCCCC0001, 4);
    send(32'hCCCC0002, 4);
    chk("rstmid_pre_occ", 32'(occupancy), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd0);
    chk("rstmid_occ", 32'(occupancy), 32'd0);
    sb_data.delete();
    sb_edge.delete();
    occ_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rstmid_in_ready_back", 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    out_cnt   = 0;
    send(32'hCCCC0003, 2);
    drain(6);
    chk("rstmid_latency", 32'(last_lat), 32'd2);
    repeat (3) tick();
    chk("rstmid_out_count", 32'(out_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
